// File: rtl/axi_pkg.sv
// Shared AXI4 types, response/burst encodings and slave FSM states.
// The response classifier decides once per transaction whether it gets OKAY, SLVERR or DECERR.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

    // Address bits at and above win_lsb must match the window base, otherwise nobody is there.
    function automatic logic [1:0] resp_class(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input int                win_lsb,
        input logic [SIZE_W-1:0] size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] diff;
        diff = (addr ^ base) >> win_lsb;
        if (diff != '0)
            return RESP_DECERR;
        if (burst == BURST_WRAP || burst == 2'b11 || size > 3'd3)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for a burst: INCR steps by 2^size with 32-bit wrap, anything else holds.
// Purely combinational, no backpressure.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [SIZE_W-1:0] i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    always_comb begin
        o_next_addr = i_addr;
        if (i_burst == BURST_INCR)
            o_next_addr = i_addr + (32'd1 << i_size);
    end

endmodule

// File: rtl/axi2sram_slave.sv
// AXI4 slave serving one transaction at a time from a 1-cycle-latency single-port SRAM.
// Reads: rvalid 3 cycles after AR/R handshake, held until rready; writes: 1 beat/cycle, bvalid held until bready.
module axi2sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h1000_0000,
    parameter int          MEM_AW = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_slave_awvalid,
    input  logic [ID_W-1:0]     io_slave_awid,
    input  logic [ADDR_W-1:0]   io_slave_awaddr,
    input  logic [LEN_W-1:0]    io_slave_awlen,
    input  logic [SIZE_W-1:0]   io_slave_awsize,
    input  logic [1:0]          io_slave_awburst,
    output logic                io_slave_awready,
    input  logic                io_slave_wvalid,
    input  logic [DATA_W-1:0]   io_slave_wdata,
    input  logic [STRB_W-1:0]   io_slave_wstrb,
    input  logic                io_slave_wlast,
    output logic                io_slave_wready,
    output logic                io_slave_bvalid,
    output logic [ID_W-1:0]     io_slave_bid,
    output logic [1:0]          io_slave_bresp,
    input  logic                io_slave_bready,
    input  logic                io_slave_arvalid,
    input  logic [ID_W-1:0]     io_slave_arid,
    input  logic [ADDR_W-1:0]   io_slave_araddr,
    input  logic [LEN_W-1:0]    io_slave_arlen,
    input  logic [SIZE_W-1:0]   io_slave_arsize,
    input  logic [1:0]          io_slave_arburst,
    output logic                io_slave_arready,
    output logic                io_slave_rvalid,
    output logic [ID_W-1:0]     io_slave_rid,
    output logic [1:0]          io_slave_rresp,
    output logic [DATA_W-1:0]   io_slave_rdata,
    output logic                io_slave_rlast,
    input  logic                io_slave_rready,
    output logic                mem_cen,
    output logic                mem_wen,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [STRB_W-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [SIZE_W-1:0]   r_size;
    logic [1:0]          r_burst;
    logic [1:0]          r_resp;
    logic [LEN_W:0]      r_beat;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_last_beat;
    logic                w_in_len;
    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_r_hs;
    logic                w_b_hs;
    logic [1:0]          w_ar_cls;
    logic [1:0]          w_aw_cls;

    axi_burst_addr u_burst_addr (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Beat counter is one bit wider than len so overlong write bursts saturate past any len.
    assign w_last_beat = (r_beat == {1'b0, r_len});
    assign w_in_len    = (r_beat <= {1'b0, r_len});
    assign w_ar_cls    = resp_class(io_slave_araddr, BASE, MEM_AW + 3, io_slave_arsize, io_slave_arburst);
    assign w_aw_cls    = resp_class(io_slave_awaddr, BASE, MEM_AW + 3, io_slave_awsize, io_slave_awburst);

    assign io_slave_arready = (r_state == ST_IDLE) && !reset;
    assign io_slave_awready = (r_state == ST_IDLE) && !reset && !io_slave_arvalid;
    assign io_slave_wready  = (r_state == ST_WR_DATA) && !reset;
    assign io_slave_rvalid  = (r_state == ST_RD_DATA) && !reset;
    assign io_slave_rlast   = io_slave_rvalid && w_last_beat;
    assign io_slave_bvalid  = (r_state == ST_WR_RESP) && !reset;
    assign io_slave_rid     = r_id;
    assign io_slave_bid     = r_id;
    assign io_slave_rresp   = r_resp;
    assign io_slave_bresp   = r_resp;
    assign io_slave_rdata   = r_rdata;

    assign w_ar_hs = io_slave_arvalid && io_slave_arready;
    assign w_aw_hs = io_slave_awvalid && io_slave_awready;
    assign w_w_hs  = io_slave_wvalid  && io_slave_wready;
    assign w_r_hs  = io_slave_rvalid  && io_slave_rready;
    assign w_b_hs  = io_slave_bvalid  && io_slave_bready;

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_cen     = 1'b0;
        mem_wen     = 1'b0;
        mem_wstrb   = '0;
        mem_wdata   = '0;
        mem_addr    = r_addr[MEM_AW+2:3];
        case (r_state)
            ST_IDLE: begin
                if (w_ar_hs)
                    w_state_nxt = ST_RD_REQ;
                else if (w_aw_hs)
                    w_state_nxt = ST_WR_DATA;
            end
            ST_RD_REQ: begin
                mem_cen     = (r_resp == RESP_OKAY) && !reset;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: w_state_nxt = ST_RD_DATA;
            ST_RD_DATA: begin
                if (w_r_hs)
                    w_state_nxt = w_last_beat ? ST_IDLE : ST_RD_REQ;
            end
            ST_WR_DATA: begin
                if (w_w_hs) begin
                    if (r_resp == RESP_OKAY && w_in_len) begin
                        mem_cen   = 1'b1;
                        mem_wen   = 1'b1;
                        mem_wstrb = io_slave_wstrb;
                        mem_wdata = io_slave_wdata;
                    end
                    if (io_slave_wlast)
                        w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_resp  <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_ar_hs) begin
                r_id    <= io_slave_arid;
                r_addr  <= io_slave_araddr;
                r_len   <= io_slave_arlen;
                r_size  <= io_slave_arsize;
                r_burst <= io_slave_arburst;
                r_resp  <= w_ar_cls;
                r_beat  <= '0;
            end else if (w_aw_hs) begin
                r_id    <= io_slave_awid;
                r_addr  <= io_slave_awaddr;
                r_len   <= io_slave_awlen;
                r_size  <= io_slave_awsize;
                r_burst <= io_slave_awburst;
                r_resp  <= w_aw_cls;
                r_beat  <= '0;
            end
            if (r_state == ST_RD_WAIT)
                r_rdata <= (r_resp == RESP_OKAY) ? mem_rdata : '0;
            if (w_r_hs && !w_last_beat) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 9'd1;
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                if (!r_beat[LEN_W])
                    r_beat <= r_beat + 9'd1;
                // A short or long burst is reported, but an address decode error takes precedence.
                if (io_slave_wlast && !w_last_beat && r_resp != RESP_DECERR)
                    r_resp <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi2sram_slave.sv
// Directed bench for axi2sram_slave with a behavioural 1-cycle-latency SRAM.
module tb_axi2sram_slave;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 0, awready;
    logic [3:0]  awid = 0;
    logic [31:0] awaddr = 0;
    logic [7:0]  awlen = 0;
    logic [2:0]  awsize = 0;
    logic [1:0]  awburst = 0;
    logic        wvalid = 0, wready, wlast = 0;
    logic [63:0] wdata = 0;
    logic [7:0]  wstrb = 0;
    logic        bvalid, bready = 0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid = 0, arready;
    logic [3:0]  arid = 0;
    logic [31:0] araddr = 0;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic [1:0]  arburst = 0;
    logic        rvalid, rlast, rready = 0;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        mem_cen, mem_wen;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;

    logic [63:0] sram [0:1023];
    logic [63:0] m_tmp;
    int          n_cen = 0;
    int          checks = 0;
    int          errors = 0;

    axi2sram_slave #(.BASE(BASE), .MEM_AW(10)) dut (
        .clock(clock), .reset(reset),
        .io_slave_awvalid(awvalid), .io_slave_awid(awid), .io_slave_awaddr(awaddr),
        .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
        .io_slave_awready(awready),
        .io_slave_wvalid(wvalid), .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
        .io_slave_wlast(wlast), .io_slave_wready(wready),
        .io_slave_bvalid(bvalid), .io_slave_bid(bid), .io_slave_bresp(bresp),
        .io_slave_bready(bready),
        .io_slave_arvalid(arvalid), .io_slave_arid(arid), .io_slave_araddr(araddr),
        .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
        .io_slave_arready(arready),
        .io_slave_rvalid(rvalid), .io_slave_rid(rid), .io_slave_rresp(rresp),
        .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rready(rready),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_cen) begin
            n_cen = n_cen + 1;
            if (mem_wen) begin
                m_tmp = sram[mem_addr];
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) m_tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
                sram[mem_addr] <= m_tmp;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = 3; arburst = 2'b01;
        #1;
        check("arready", 64'(arready), 64'd1);
        tick();
        arvalid = 0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = 3; awburst = burst;
        #1;
        check("awready", 64'(awready), 64'd1);
        tick();
        awvalid = 0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        wvalid = 1; wdata = d; wstrb = s; wlast = l;
        tick();
        wvalid = 0; wlast = 0;
    endtask

    task automatic rd_beat(input string tag, input logic [63:0] exp_d, input logic [1:0] exp_resp,
                           input logic exp_last, input int stall);
        int n = 0;
        while (!rvalid && n < 8) begin tick(); n++; end
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check({tag, "_rdata"}, rdata, exp_d);
        check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        check({tag, "_rlast"}, 64'(rlast), 64'(exp_last));
        if (stall > 0) begin
            repeat (stall) tick();
            check({tag, "_hold_rvalid"}, 64'(rvalid), 64'd1);
            check({tag, "_hold_rdata"}, rdata, exp_d);
        end
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic b_wait(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        while (!bvalid && n < 8) begin tick(); n++; end
        check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        check({tag, "_bid"}, 64'(bid), 64'(exp_id));
        check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        bready = 1;
        tick();
        bready = 0;
        check({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 64'd0;
        for (int i = 0; i < 8; i++) sram[i] = {32'hC0DE_0000, 32'(i)};
        sram[5] = 64'hDEAD_BEEF_0123_4567;

        // Reset state
        arvalid = 1; awvalid = 1;
        repeat (3) tick();
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_cen", 64'(mem_cen), 64'd0);
        arvalid = 0; awvalid = 0;
        reset = 0;
        #1;
        check("idle_awready", 64'(awready), 64'd1);

        // Single read: word 5, exact latency
        send_ar(4'd3, BASE + 32'h28, 8'd0);
        check("t1_cen", 64'(mem_cen), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'd5);
        tick();
        check("t1_rvalid_t2", 64'(rvalid), 64'd0);
        tick();
        check("t1_rvalid_t3", 64'(rvalid), 64'd1);
        check("t1_rid", 64'(rid), 64'd3);
        rd_beat("t1", 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b1, 0);
        check("t1_idle", 64'(rvalid), 64'd0);

        // INCR len=3 with a stall on beat 1
        send_ar(4'd1, BASE, 8'd3);
        rd_beat("t2b0", {32'hC0DE_0000, 32'd0}, 2'b00, 1'b0, 0);
        rd_beat("t2b1", {32'hC0DE_0000, 32'd1}, 2'b00, 1'b0, 4);
        rd_beat("t2b2", {32'hC0DE_0000, 32'd2}, 2'b00, 1'b0, 0);
        rd_beat("t2b3", {32'hC0DE_0000, 32'd3}, 2'b00, 1'b1, 0);

        // Write len=1: partial strobe then full
        sram[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        sram[1] = 64'h0;
        send_aw(4'd9, BASE, 8'd1, 2'b01);
        check("t3_wready", 64'(wready), 64'd1);
        wvalid = 1; wdata = 64'h1111_2222_3333_4444; wstrb = 8'h0F; wlast = 0;
        #1;
        check("t3_cen", 64'(mem_cen), 64'd1);
        check("t3_wen", 64'(mem_wen), 64'd1);
        check("t3_wstrb", 64'(mem_wstrb), 64'h0F);
        tick();
        w_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
        check("t3_bvalid_next", 64'(bvalid), 64'd1);
        b_wait("t3", 4'd9, 2'b00);
        check("t3_word0", sram[0], 64'hAAAA_AAAA_3333_4444);
        check("t3_word1", sram[1], 64'h5555_6666_7777_8888);

        // AR and AW together: read first, write one cycle after last R handshake
        arvalid = 1; arid = 4; araddr = BASE + 32'h10; arlen = 0; arsize = 3; arburst = 2'b01;
        awvalid = 1; awid = 5; awaddr = BASE + 32'h18; awlen = 0; awsize = 3; awburst = 2'b01;
        #1;
        check("t4_arready", 64'(arready), 64'd1);
        check("t4_awready_id", 64'(awready), 64'd0);
        tick();
        arvalid = 0;
        #1;
        check("t4_awready_rd", 64'(awready), 64'd0);
        rd_beat("t4", {32'hC0DE_0000, 32'd2}, 2'b00, 1'b1, 0);
        check("t4_awready_after", 64'(awready), 64'd1);
        tick();
        awvalid = 0;
        w_beat(64'h0BAD_F00D_1234_5678, 8'hFF, 1'b1);
        b_wait("t4", 4'd5, 2'b00);
        check("t4_word3", sram[3], 64'h0BAD_F00D_1234_5678);

        // Decode error read and WRAP write
        n_cen = 0;
        send_ar(4'd7, 32'h0000_0000, 8'd1);
        rd_beat("t5b0", 64'd0, 2'b11, 1'b0, 0);
        rd_beat("t5b1", 64'd0, 2'b11, 1'b1, 0);
        sram[6] = 64'h6666_6666_6666_6666;
        send_aw(4'd2, BASE + 32'h30, 8'd0, 2'b10);
        w_beat(64'h1234_1234_1234_1234, 8'hFF, 1'b1);
        b_wait("t5", 4'd2, 2'b10);
        check("t5_word6", sram[6], 64'h6666_6666_6666_6666);
        check("t5_no_cen", 64'(n_cen), 64'd0);

        // Short write burst reports SLVERR
        send_aw(4'd6, BASE + 32'h38, 8'd2, 2'b01);
        w_beat(64'h7777_0000_7777_0000, 8'hFF, 1'b1);
        b_wait("t5s", 4'd6, 2'b10);

        // Reset during beat 2 of a len=7 read, then a fresh read
        for (int i = 0; i < 8; i++) sram[i] = {32'hBEEF_0000, 32'(i)};
        send_ar(4'd1, BASE, 8'd7);
        rd_beat("t6b0", {32'hBEEF_0000, 32'd0}, 2'b00, 1'b0, 0);
        rd_beat("t6b1", {32'hBEEF_0000, 32'd1}, 2'b00, 1'b0, 0);
        begin
            int n = 0;
            while (!rvalid && n < 8) begin tick(); n++; end
        end
        check("t6_b2_rvalid", 64'(rvalid), 64'd1);
        reset = 1;
        tick();
        check("t6_rvalid", 64'(rvalid), 64'd0);
        check("t6_rlast", 64'(rlast), 64'd0);
        check("t6_rdata", rdata, 64'd0);
        check("t6_rid", 64'(rid), 64'd0);
        check("t6_arready", 64'(arready), 64'd0);
        check("t6_cen", 64'(mem_cen), 64'd0);
        reset = 0;
        #1;
        check("t6_idle_arready", 64'(arready), 64'd1);
        send_ar(4'd3, BASE + 32'h28, 8'd0);
        rd_beat("t6f", {32'hBEEF_0000, 32'd5}, 2'b00, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
